// File: rtl/svcs_trnx_deframer.sv
// SVCS receive deframer: parses a 4-word transaction header from the raw word
// stream, presents it on a handshake port, then passes n_payloads words through
// with index and last marker. Oversized transactions are drained and flagged.
module svcs_trnx_deframer #(
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_PAYLOADS = 4096,
  parameter int unsigned CW           = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          hdr_valid,
  input  logic          hdr_ready,
  output logic [DW-1:0] hdr_trnx_type,
  output logic [DW-1:0] hdr_trnx_id,
  output logic [DW-1:0] hdr_data_type,
  output logic [DW-1:0] hdr_n_payloads,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_idx,
  output logic          out_last,
  output logic          err_oversize,
  output logic [15:0]   trnx_count,
  output logic          busy
);

  typedef enum logic [1:0] {StHdr, StHdrOut, StPayload, StDrain} state_e;

  state_e        state_q, state_d;
  logic [1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [DW-1:0] type_q, type_d;
  logic [DW-1:0] id_q, id_d;
  logic [DW-1:0] dtype_q, dtype_d;
  logic [DW-1:0] npl_q, npl_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHdr;
      hdr_cnt_q <= 2'd0;
      type_q    <= '0;
      id_q      <= '0;
      dtype_q   <= '0;
      npl_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      type_q    <= type_d;
      id_q      <= id_d;
      dtype_q   <= dtype_d;
      npl_q     <= npl_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    type_d    = type_q;
    id_d      = id_q;
    dtype_d   = dtype_q;
    npl_d     = npl_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    hdr_valid = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;

    unique case (state_q)
      StHdr: begin
        in_ready = 1'b1;
        if (in_valid) begin
          unique case (hdr_cnt_q)
            2'd0: type_d  = in_data;
            2'd1: id_d    = in_data;
            2'd2: dtype_d = in_data;
            2'd3: npl_d   = in_data;
          endcase
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (in_data > DW'(MAX_PAYLOADS)) begin
              err_d   = 1'b1;
              rem_d   = in_data;
              state_d = StDrain;
            end else begin
              state_d = StHdrOut;
            end
          end
        end
      end
      StHdrOut: begin
        hdr_valid = 1'b1;
        if (hdr_ready) begin
          if (npl_q == '0) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = StHdr;
          end else begin
            rem_d   = npl_q;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        // Zero-latency pass-through; downstream backpressure stalls the source.
        out_valid = in_valid;
        in_ready  = out_ready;
        out_last  = (rem_q == DW'(1));
        if (in_valid && out_ready) begin
          rem_d = rem_q - DW'(1);
          idx_d = idx_q + CW'(1);
          if (rem_q == DW'(1)) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = StHdr;
          end
        end
      end
      StDrain: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rem_d = rem_q - DW'(1);
          if (rem_q == DW'(1)) state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  // Registered fields and status outputs.
  always_comb begin
    hdr_trnx_type  = type_q;
    hdr_trnx_id    = id_q;
    hdr_data_type  = dtype_q;
    hdr_n_payloads = npl_q;
    out_data       = in_data;
    out_idx        = (state_q == StPayload) ? idx_q : '0;
    err_oversize   = err_q;
    trnx_count     = cnt_q;
    busy           = (state_q != StHdr) || (hdr_cnt_q != 2'd0);
  end

endmodule

// File: doc/svcs_trnx_deframer.md
Name: svcs_trnx_deframer

Overview:
- Hardware receive-side stage of the SVCS client/server link.
- Consumes the raw 32-bit word stream delivered by the socket/DPI receive bridge.
- Parses the 4-word transaction header: trnx_type, trnx_id, data_type, n_payloads.
- Presents the header on a handshake port, then streams exactly n_payloads payload words downstream with index and last marker.

Parameters:
- DW, 32: word width of input and payload streams.
- MAX_PAYLOADS, 4096: largest legal n_payloads; equals the link's SVCS max size.
- CW, 13: payload index width; must satisfy 2**CW > MAX_PAYLOADS.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DW  input word.
- hdr_valid  out  1  parsed header available.
- hdr_ready  in  1  header consumed.
- hdr_trnx_type  out  DW  header word 0.
- hdr_trnx_id  out  DW  header word 1.
- hdr_data_type  out  DW  header word 2.
- hdr_n_payloads  out  DW  header word 3.
- out_valid  out  1  payload word valid.
- out_ready  in  1  payload word consumed.
- out_data  out  DW  payload word.
- out_idx  out  CW  0-based payload index within the transaction.
- out_last  out  1  marks the final payload word.
- err_oversize  out  1  one-cycle pulse; n_payloads > MAX_PAYLOADS.
- trnx_count  out  16  transactions completed (wraps).
- busy  out  1  high whenever state != HDR or hdr_cnt != 0.

Behaviour:
- Reset, synchronous on rst=1: state=HDR; hdr_cnt=0; all hdr_* fields 0; hdr_valid=0; out_valid=0; out_idx=0; out_last=0; err_oversize=0; trnx_count=0; busy=0.
- Reset wins over every simultaneous event. Reset mid-transaction discards the partial header/payload with no error pulse.
- State HDR: in_ready=1.
  - Each accepted word is registered into the field selected by hdr_cnt (0..3), and hdr_cnt increments.
  - On acceptance of word 3, hdr_cnt returns to 0. Next state depends on n_payloads (the word just accepted):
  - n_payloads > MAX_PAYLOADS: pulse err_oversize for the cycle after acceptance, load rem=n_payloads, go to DRAIN. hdr_valid is never raised.
  - Otherwise: go to HDR_OUT. hdr_valid rises the cycle after word 3 is accepted (1-cycle latency).
- State HDR_OUT: in_ready=0. hdr_valid=1 and all hdr_* fields are held stable until hdr_ready.
  - On the hdr_valid && hdr_ready cycle: if n_payloads==0, increment trnx_count and go to HDR; else load rem=n_payloads, out_idx=0, go to PAYLOAD.
- State PAYLOAD: zero-latency combinational pass-through.
  - out_valid = in_valid; in_ready = out_ready; out_data = in_data.
  - out_last = (rem==1).
  - A beat transfers when in_valid && out_ready: rem decrements and out_idx increments.
  - On the beat with out_last=1: increment trnx_count, go to HDR.
  - hdr_valid=0 in this state; header field registers keep their last values.
- State DRAIN: in_ready=1, out_valid=0. Accepted words are discarded and rem decrements; at rem reaching 0, go to HDR. trnx_count is not incremented.
- rem is a DW-bit counter, so a drain covers the full 32-bit n_payloads count.
- out_idx and out_last are driven 0 outside PAYLOAD. out_valid is 0 outside PAYLOAD.
- Backpressure: out_ready=0 in PAYLOAD forces in_ready=0. No word is dropped or duplicated.
- hdr_ready is ignored outside HDR_OUT.
- trnx_count wraps 16'hFFFF -> 0.
- Back-to-back transactions: word 0 of the next header may be accepted the cycle after the last payload beat. There are no idle cycles between transactions beyond the 1-cycle HDR_OUT entry.

Test Plan:
- Words {0x11,0x22,0x33,3,0xA,0xB,0xC}, hdr_ready and out_ready held 1 -> hdr_valid one cycle with fields 0x11/0x22/0x33/3. Then out_data A,B,C with out_idx 0,1,2 and out_last only on C. trnx_count=1.
- n_payloads=0 header, then a second header with n=1 and payload 0x5 -> first completes with no out_valid and trnx_count=1; second emits 0x5 with out_last=1 and trnx_count=2.
- n=4 payload with out_ready toggling 1,0,0,1,... -> in_ready mirrors out_ready; 4 beats delivered in order, no loss; out_idx increments only on transfer.
- Header with n=4097, then 4097 words, then a valid n=1 transaction -> err_oversize single pulse; no hdr_valid/out_valid during drain; next transaction parsed correctly; trnx_count=1.
- hdr_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0, fields stable; on hdr_ready=1, payload starts the following cycle.
- rst asserted after payload beat 2 of 5 -> all outputs at reset values next cycle. A fresh header afterwards parses from word 0.
